// File: rtl/pattern_serializer_if.sv
// -----------------------------------------------------------------------------
// pattern_serializer_if
// Request/serial-stream bundle for pattern_serializer.
//   start     : request a new transfer (host -> serializer)
//   pattern   : WIDTH-bit pattern, sent MSB first (host -> serializer)
//   reps      : repeat count, pattern is sent reps+1 times (host -> serializer)
//   abort     : synchronous cancel of the running transfer (host -> serializer)
//   ready     : serializer idle, start will be accepted (serializer -> host)
//   out       : serial data bit (serializer -> host)
//   out_valid : out carries a pattern bit this cycle (serializer -> host)
//   done      : one-cycle pulse after the final bit (serializer -> host)
// -----------------------------------------------------------------------------
interface pattern_serializer_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 3
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             done;

    modport master (
        output start, pattern, reps, abort,
        input  ready, out, out_valid, done
    );

    modport slave (
        input  start, pattern, reps, abort,
        output ready, out, out_valid, done
    );
endinterface

// File: rtl/pattern_serializer.sv
// -----------------------------------------------------------------------------
// pattern_serializer
// Sends a latched WIDTH-bit pattern MSB first, reps+1 times, with GAP idle
// zero cycles between repetitions, then pulses done for one cycle.
// Ports:
//   clk  : single clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : pattern_serializer_if.slave (start/pattern/reps/abort in,
//          ready/out/out_valid/done out)
// All outputs are registered: each output reflects the state the FSM held
// during the previous cycle, so the first bit appears one cycle after the
// state has moved to SHIFT.
// -----------------------------------------------------------------------------
module pattern_serializer #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    parameter int REP_W = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    pattern_serializer_if.slave    bus
);
    localparam int                 IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [2:0]         GAP_TOP = 3'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       gap_q, gap_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is checked inside the clocked block,
    // which makes it synchronous.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b1;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        pat_d    = pat_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        ready_d  = 1'b0;
        out_d    = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        if (state != ST_IDLE && bus.abort) begin
            // Cancel: back to IDLE with quiet outputs and ready raised.
            state_nx = ST_IDLE;
            ready_d  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // ready_q is low in the first IDLE cycle after DONE, so a
                    // start there is not taken.
                    if (bus.start && ready_q) begin
                        state_nx = ST_SHIFT;
                        pat_d    = bus.pattern;
                        rep_d    = bus.reps;
                        idx_d    = IDX_TOP;
                    end else begin
                        ready_d  = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    out_d   = pat_q[idx_q];
                    valid_d = 1'b1;
                    if (idx_q == '0) begin
                        idx_d = IDX_TOP;
                        if (rep_q == '0) begin
                            state_nx = ST_DONE;
                        end else begin
                            rep_d = rep_q - REP_W'(1);
                            // With GAP=0 the state stays SHIFT: back-to-back.
                            if (GAP > 0) begin
                                state_nx = ST_GAP;
                                gap_d    = GAP_TOP;
                            end
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_nx = ST_SHIFT;
                    end else begin
                        gap_d = gap_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    done_d   = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.done      = done_q;
endmodule

// File: doc/pattern_serializer.md
PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the pattern length in bits (range 2..16).
REQ-002 Parameter GAP, default 2, SHALL set the idle zero-bit count inserted between repetitions (range 0..7).
REQ-003 Parameter REP_W, default 3, SHALL set the width of the repeat field.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rstn, input, 1, SHALL be the reset: synchronous and active-low.
REQ-006 Port start, input, 1, SHALL request a new transfer; it is sampled only while ready=1.
REQ-007 Port pattern, input, WIDTH, SHALL be the bit pattern, latched on acceptance and sent MSB first.
REQ-008 Port reps, input, REP_W, SHALL be latched on acceptance; the pattern is sent reps+1 times.
REQ-009 Port abort, input, 1, SHALL be a synchronous cancel of the current transfer.
REQ-010 Port ready, output, 1, SHALL indicate that the block is in IDLE and can accept start.
REQ-011 Port out, output, 1, SHALL be the serial data bit.
REQ-012 Port out_valid, output, 1, SHALL mark cycles in which out carries a pattern bit.
REQ-013 Port done, output, 1, SHALL be a one-cycle pulse after the last bit of the last repetition.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-015 IDLE: ready=1, out=0, out_valid=0, done=0.
REQ-016 IDLE to SHIFT on start=1 at edge k; pattern and reps SHALL be captured at edge k.
REQ-017 Latency: the first bit (pattern[WIDTH-1]) SHALL be on out with out_valid=1 in the cycle after edge k+1.
REQ-018 SHIFT: one bit per cycle, MSB to LSB, for exactly WIDTH cycles; ready=0.
REQ-019 After the LSB, the FSM SHALL go to GAP if repetitions remain and GAP>0.
REQ-020 After the LSB, the FSM SHALL go directly to SHIFT, back-to-back, if repetitions remain and GAP=0.
REQ-021 After the LSB of the final repetition, the FSM SHALL go to DONE.
REQ-022 GAP: out=0 and out_valid=0 for exactly GAP cycles, then SHIFT, restarting at the MSB.
REQ-023 DONE: done=1, ready=0, out=0, out_valid=0 for exactly one cycle, then IDLE.
REQ-024 The bit index counter SHALL be ceil(log2(WIDTH)) bits and SHALL wrap to WIDTH-1 at each repetition start.
REQ-025 The repetition counter SHALL decrement once per completed pattern; reps=0 SHALL produce exactly one pattern.
REQ-026 Total cycles from the first bit to the done pulse inclusive SHALL be (reps+1)*WIDTH + reps*GAP + 1.
REQ-027 start while ready=0 SHALL be ignored, with no queuing; pattern and reps changes after acceptance SHALL have no effect.
REQ-028 abort=1 in SHIFT, GAP or DONE SHALL force IDLE at the next edge with out=0, out_valid=0 and done=0; abort in IDLE SHALL be ignored.
REQ-029 When abort and start coincide in IDLE, start SHALL be accepted.
REQ-030 The serial stream SHALL be directly consumable by the nonoverlap_1010 detector (out to in, same clk and rstn).

Reset
REQ-031 rstn=0 sampled at an edge SHALL force IDLE with ready=1 and out=out_valid=done=0.
REQ-032 rstn=0 sampled at an edge SHALL clear the pattern, repetition and index registers to 0.
REQ-033 Reset mid-transfer SHALL abort without a done pulse; rstn SHALL take priority over abort and start.
REQ-034 rstn=0 SHALL have no effect until the next rising edge of clk.

Verification
REQ-035 pattern=4'b1010, reps=0 -> out=1,0,1,0 with out_valid=1 for 4 cycles, done high in cycle 5, ready=1 in cycle 6.
REQ-036 pattern=4'b1010, reps=1, GAP=2 -> out=1,0,1,0,0,0,1,0,1,0; out_valid=1111001111; done one cycle later (11 cycles total).
REQ-037 start pulsed with pattern=4'b1111 during a 4'b1010 transfer -> stream unchanged, second request dropped, ready=0 throughout.
REQ-038 rstn=0 on the 3rd SHIFT cycle -> next edge out=0, out_valid=0, ready=1, done never asserted; a new start is accepted normally.
REQ-039 abort in a GAP cycle (reps=3) -> IDLE next edge, no further bits, no done pulse.
REQ-040 Loopback to nonoverlap_1010 with pattern=4'b1010, reps=2, GAP=0 -> detector out asserts exactly 3 times, once per pattern.
